// File: rtl/drive_pkg.sv
// drive_pkg -- shared types and helpers for the drive sequencer.
//   drive_cmd_t : drive command encoding (codes 6/7 are not members, they read as Stop)
//   seq_state_t : sequencer FSM state encoding, exported on seq_state
//   norm_cmd    : maps a raw 3-bit code onto drive_cmd_t
//   is_reversal : true when two commands sit on opposite sides (left vs right)
package drive_pkg;

  typedef enum logic [2:0] {
    CMD_STOP       = 3'd0,
    CMD_FAST_LEFT  = 3'd1,
    CMD_LEFT       = 3'd2,
    CMD_STRAIGHT   = 3'd3,
    CMD_RIGHT      = 3'd4,
    CMD_FAST_RIGHT = 3'd5
  } drive_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2,
    ST_ESTOP = 2'd3
  } seq_state_t;

  function automatic drive_cmd_t norm_cmd(input logic [2:0] c);
    return (c > 3'd5) ? CMD_STOP : drive_cmd_t'(c);
  endfunction

  function automatic logic is_left(input drive_cmd_t c);
    return (c == CMD_FAST_LEFT) || (c == CMD_LEFT);
  endfunction

  function automatic logic is_right(input drive_cmd_t c);
    return (c == CMD_RIGHT) || (c == CMD_FAST_RIGHT);
  endfunction

  function automatic logic is_reversal(input drive_cmd_t a, input drive_cmd_t b);
    return (is_left(a) && is_right(b)) || (is_right(a) && is_left(b));
  endfunction

endpackage

// File: rtl/drive_seq_timer.sv
// drive_seq_timer -- shared ramp/dwell cycle counter.
// One counter serves both purposes: RUN uses it as a ramp interval (the
// sequencer clears it on every ramp tick), DWELL uses it as the stop-dwell
// length. It saturates at the longer of the two so it never wraps.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   i_clr         : synchronous clear (state change, dwell restart, ramp tick)
//   o_ramp_tick   : counter has reached RAMP_CYCLES-1
//   o_dwell_done  : counter has reached DWELL_CYCLES-1
module drive_seq_timer #(
  parameter int RAMP_CYCLES  = 500000,
  parameter int DWELL_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_ramp_tick,
  output logic o_dwell_done
);

  localparam int MAXC = (DWELL_CYCLES > RAMP_CYCLES) ? DWELL_CYCLES : RAMP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] RAMP_LAST  = TW'(RAMP_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] MAX_LAST   = TW'(MAXC - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_cnt <= '0;
    else if (i_clr)             r_cnt <= '0;
    else if (r_cnt != MAX_LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign o_ramp_tick  = (r_cnt == RAMP_LAST);
  assign o_dwell_done = (r_cnt == DWELL_LAST);

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer -- arbitrates auto/manual drive commands, ramps speed,
// enforces a stop-dwell on left/right reversals and handles emergency stop.
// Optional feature: define DRIVE_SEQ_WATCHDOG_EN to drop RUN back to IDLE
// when the selected source goes silent for WATCHDOG_CYCLES.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   auto_cmd/auto_valid       : autonomous command + qualifier
//   manual_cmd/manual_valid   : IR remote command + qualifier
//   manual_mode               : 1 = manual source, 0 = auto source
//   speed_limit               : maximum speed 0-3
//   estop                     : emergency stop (level)
//   motor_ready               : motor driver accepts payload
//   motor_cmd/motor_speed     : sequenced payload
//   motor_valid               : payload pending
//   seq_state                 : FSM state (IDLE/RUN/DWELL/ESTOP)
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int DWELL_CYCLES    = 5000000,
  parameter int RAMP_CYCLES     = 500000,
  parameter int WATCHDOG_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] auto_cmd,
  input  logic       auto_valid,
  input  logic [2:0] manual_cmd,
  input  logic       manual_valid,
  input  logic       manual_mode,
  input  logic [1:0] speed_limit,
  input  logic       estop,
  input  logic       motor_ready,
  output logic [2:0] motor_cmd,
  output logic [1:0] motor_speed,
  output logic       motor_valid,
  output logic [1:0] seq_state
);

  seq_state_t r_state, w_next;
  drive_cmd_t r_cmd, r_pend, w_cmd_n, w_pend_n, w_sel_cmd;
  logic [1:0] r_speed, w_speed_n;
  logic       r_valid;
  logic       w_sel_valid, w_go, w_stop, w_restart, w_tmr_clr;
  logic       w_ramp_tick, w_dwell_done, w_wd_to;

  // Source switch is purely combinational: nothing happens until the newly
  // selected source presents a valid.
  assign w_sel_valid = manual_mode ? manual_valid : auto_valid;
  assign w_sel_cmd   = norm_cmd(manual_mode ? manual_cmd : auto_cmd);
  assign w_go        = w_sel_valid && (w_sel_cmd != CMD_STOP);
  assign w_stop      = w_sel_valid && (w_sel_cmd == CMD_STOP);

`ifdef DRIVE_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WW-1:0] r_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_wd <= '0;
    else if (estop || r_state != ST_RUN || w_sel_valid) r_wd <= '0;
    else if (!w_wd_to)                            r_wd <= r_wd + 1'b1;
  end

  assign w_wd_to = (r_state == ST_RUN) && !w_sel_valid &&
                   (r_wd == WW'(WATCHDOG_CYCLES - 1));
`else
  // No timeout; the parameter stays on the interface so both builds share it.
  assign w_wd_to = (WATCHDOG_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (estop) w_next = ST_ESTOP;
    else begin
      case (r_state)
        ST_IDLE:  if (w_go && speed_limit != 2'd0) w_next = ST_RUN;
        ST_RUN: begin
          if (speed_limit == 2'd0 || w_wd_to || w_stop) w_next = ST_IDLE;
          else if (w_go && is_reversal(r_cmd, w_sel_cmd)) w_next = ST_DWELL;
        end
        ST_DWELL: begin
          if (w_stop) w_next = ST_IDLE;
          else if (w_go && is_reversal(r_pend, w_sel_cmd)) w_next = ST_DWELL;
          else if (w_dwell_done) w_next = (speed_limit == 2'd0) ? ST_IDLE : ST_RUN;
        end
        ST_ESTOP: if (w_stop) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Output logic: next payload and pending command
  always_comb begin
    w_cmd_n   = r_cmd;
    w_speed_n = r_speed;
    w_pend_n  = r_pend;
    w_restart = 1'b0;
    case (w_next)
      ST_IDLE, ST_ESTOP: begin
        w_cmd_n   = CMD_STOP;
        w_speed_n = 2'd0;
      end
      ST_DWELL: begin
        w_cmd_n   = CMD_STOP;
        w_speed_n = 2'd0;
        if (r_state != ST_DWELL) w_pend_n = w_sel_cmd;
        else if (w_go) begin
          w_pend_n = w_sel_cmd;
          // Reversing against the pending command restarts the dwell.
          w_restart = is_reversal(r_pend, w_sel_cmd);
        end
      end
      ST_RUN: begin
        if (r_state == ST_RUN) begin
          if (w_go) w_cmd_n = w_sel_cmd;
          if (r_speed > speed_limit) w_speed_n = speed_limit;
          else if (w_ramp_tick && r_speed < speed_limit) w_speed_n = r_speed + 2'd1;
        end else begin
          w_cmd_n   = (r_state == ST_DWELL && !w_go) ? r_pend : w_sel_cmd;
          w_speed_n = 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Timer restarts on every state change, while parked, on each ramp step
  // and on a dwell restart.
  assign w_tmr_clr = (w_next != r_state) ||
                     (r_state == ST_IDLE) || (r_state == ST_ESTOP) ||
                     (r_state == ST_RUN && w_ramp_tick) || w_restart;

  drive_seq_timer #(
    .RAMP_CYCLES  (RAMP_CYCLES),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_tmr_clr),
    .o_ramp_tick  (w_ramp_tick),
    .o_dwell_done (w_dwell_done)
  );

  // Payload register. motor_valid rises together with the new payload and
  // a newer payload simply overwrites a pending one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd   <= CMD_STOP;
      r_speed <= 2'd0;
      r_pend  <= CMD_STOP;
      r_valid <= 1'b0;
    end else begin
      r_cmd   <= w_cmd_n;
      r_speed <= w_speed_n;
      r_pend  <= w_pend_n;
      if (w_cmd_n != r_cmd || w_speed_n != r_speed) r_valid <= 1'b1;
      else if (motor_ready)                         r_valid <= 1'b0;
    end
  end

  assign motor_cmd   = r_cmd;
  assign motor_speed = r_speed;
  assign motor_valid = r_valid;
  assign seq_state   = r_state;

endmodule
